// File: rtl/flag_pkg.sv
// Shared definitions for the condition-flag pipeline: flag vector layout
// and the architectural reset value.
package flag_pkg;

    localparam int FLAG_W = 4;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [FLAG_W-1:0] flags_t;

    // A cleared datapath result reads as zero, so only Z is set.
    localparam flags_t ARCH_RESET = 4'b1000;

endpackage : flag_pkg

// File: rtl/flag_calc.sv
// Combinational Z/N/C/V flag generation from one ALU result.
module flag_calc
    import flag_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] result_i,
    input  logic             carry_i,
    input  logic             ovf_i,
    output flags_t           flags_o
);

    always_comb begin
        flags_o         = '0;
        flags_o[FLAG_Z] = ~|result_i;
        flags_o[FLAG_N] = result_i[WIDTH-1];
        flags_o[FLAG_C] = carry_i;
        flags_o[FLAG_V] = ovf_i;
    end

endmodule : flag_calc

// File: rtl/flag_fwd_pipe.sv
// DEPTH-stage condition-flag pipeline with stall/flush, an architectural
// flag register fed by the oldest stage, and youngest-first forwarding.
module flag_fwd_pipe
    import flag_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    write_i,
    input  logic [WIDTH-1:0]        in_i,
    input  logic                    carry_in_i,
    input  logic                    ovf_in_i,
    input  logic                    stall_i,
    input  logic                    flush_i,
    output logic [FLAG_W*DEPTH-1:0] stage_flags_o,
    output logic [DEPTH-1:0]        stage_valid_o,
    output logic [FLAG_W-1:0]       arch_flags_o,
    output logic [FLAG_W-1:0]       fwd_flags_o,
    output logic                    fwd_hit_o
);

    flags_t                         new_flags;
    logic [DEPTH-1:0][FLAG_W-1:0]   flags_q;
    logic [DEPTH-1:0][FLAG_W-1:0]   flags_d;
    logic [DEPTH-1:0]               valid_q;
    logic [DEPTH-1:0]               valid_d;
    flags_t                         arch_q;
    flags_t                         arch_d;
    flags_t                         fwd_flags;
    logic                           advance;

    flag_calc #(
        .WIDTH (WIDTH)
    ) u_flag_calc (
        .result_i (in_i),
        .carry_i  (carry_in_i),
        .ovf_i    (ovf_in_i),
        .flags_o  (new_flags)
    );

    assign advance = ~flush_i & ~stall_i;

    // Flush only kills valid bits; flag payloads stay where they are.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_stage
            if (gi == 0) begin : gen_head
                assign flags_d[gi] = advance ? (write_i ? new_flags : '0) : flags_q[gi];
                assign valid_d[gi] = flush_i ? 1'b0
                                   : (advance ? write_i : valid_q[gi]);
            end else begin : gen_body
                assign flags_d[gi] = advance ? flags_q[gi-1] : flags_q[gi];
                assign valid_d[gi] = flush_i ? 1'b0
                                   : (advance ? valid_q[gi-1] : valid_q[gi]);
            end
        end
    endgenerate

    // Only a valid oldest entry retires, and only on an advancing cycle.
    assign arch_d = (advance && valid_q[DEPTH-1]) ? flags_q[DEPTH-1] : arch_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flags_q <= '0;
            valid_q <= '0;
            arch_q  <= ARCH_RESET;
        end else begin
            flags_q <= flags_d;
            valid_q <= valid_d;
            arch_q  <= arch_d;
        end
    end

    // Scan oldest to youngest so the lowest-index valid stage wins.
    always_comb begin
        fwd_flags = arch_q;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            if (valid_q[s]) begin
                fwd_flags = flags_q[s];
            end
        end
    end

    assign stage_flags_o = flags_q;
    assign stage_valid_o = valid_q;
    assign arch_flags_o  = arch_q;
    assign fwd_flags_o   = fwd_flags;
    assign fwd_hit_o     = |valid_q;

endmodule : flag_fwd_pipe

// File: tb/tb_flag_fwd_pipe.sv
// Directed vector bench for flag_fwd_pipe (WIDTH=32, DEPTH=3).
module tb_flag_fwd_pipe;
    localparam int WIDTH = 32;
    localparam int DEPTH = 3;

    logic              clk;
    logic              rst_n;
    logic              write;
    logic [WIDTH-1:0]  in_val;
    logic              carry;
    logic              ovf;
    logic              stall;
    logic              flush;
    logic [4*DEPTH-1:0] stage_flags;
    logic [DEPTH-1:0]  stage_valid;
    logic [3:0]        arch_flags;
    logic [3:0]        fwd_flags;
    logic              fwd_hit;

    int tests_run;
    int tests_failed;

    flag_fwd_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .write_i       (write),
        .in_i          (in_val),
        .carry_in_i    (carry),
        .ovf_in_i      (ovf),
        .stall_i       (stall),
        .flush_i       (flush),
        .stage_flags_o (stage_flags),
        .stage_valid_o (stage_valid),
        .arch_flags_o  (arch_flags),
        .fwd_flags_o   (fwd_flags),
        .fwd_hit_o     (fwd_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        write;
        logic [31:0] in;
        logic        c;
        logic        v;
        logic [2:0]  ev;
        logic [11:0] ef;
        logic [3:0]  ea;
        logic [3:0]  efw;
        logic        eh;
    } vec_t;

    localparam int NVEC = 31;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic s, input logic f, input logic w,
                                input logic [31:0] d, input logic c, input logic v,
                                input logic [2:0] ev, input logic [11:0] ef,
                                input logic [3:0] ea, input logic [3:0] efw,
                                input logic eh);
        vec_t r;
        r.stall = s; r.flush = f; r.write = w; r.in = d; r.c = c; r.v = v;
        r.ev = ev; r.ef = ef; r.ea = ea; r.efw = efw; r.eh = eh;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] ev, input logic [11:0] ef,
                             input logic [3:0] ea, input logic [3:0] efw, input logic eh);
        check({tag, " valid"}, 32'(stage_valid), 32'(ev));
        check({tag, " stage_flags"}, 32'(stage_flags), 32'(ef));
        check({tag, " arch"}, 32'(arch_flags), 32'(ea));
        check({tag, " fwd_flags"}, 32'(fwd_flags), 32'(efw));
        check({tag, " fwd_hit"}, 32'(fwd_hit), 32'(eh));
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        //                 stall flush wr  in            c  v  valid  stage_flags arch  fwd  hit
        // write and retire
        vecs[0]  = mk(0, 0, 1, 32'h8000_0000, 1, 0, 3'b001, 12'h006, 4'h8, 4'h6, 1);
        vecs[1]  = mk(0, 0, 0, 32'h0,         0, 0, 3'b010, 12'h060, 4'h8, 4'h6, 1);
        vecs[2]  = mk(0, 0, 0, 32'h0,         0, 0, 3'b100, 12'h600, 4'h8, 4'h6, 1);
        vecs[3]  = mk(0, 0, 0, 32'h0,         0, 0, 3'b000, 12'h000, 4'h6, 4'h6, 0);
        // back-to-back writes
        vecs[4]  = mk(0, 0, 1, 32'h0,         0, 0, 3'b001, 12'h008, 4'h6, 4'h8, 1);
        vecs[5]  = mk(0, 0, 1, 32'h5,         0, 0, 3'b011, 12'h080, 4'h6, 4'h0, 1);
        vecs[6]  = mk(0, 0, 0, 32'h0,         0, 0, 3'b110, 12'h800, 4'h6, 4'h0, 1);
        vecs[7]  = mk(0, 0, 0, 32'h0,         0, 0, 3'b100, 12'h000, 4'h8, 4'h0, 1);
        vecs[8]  = mk(0, 0, 0, 32'h0,         0, 0, 3'b000, 12'h000, 4'h0, 4'h0, 0);
        // stall drops writes and holds everything
        vecs[9]  = mk(0, 0, 1, 32'h0,         0, 0, 3'b001, 12'h008, 4'h0, 4'h8, 1);
        vecs[10] = mk(1, 0, 1, 32'h7,         0, 0, 3'b001, 12'h008, 4'h0, 4'h8, 1);
        vecs[11] = mk(1, 0, 1, 32'h7,         0, 0, 3'b001, 12'h008, 4'h0, 4'h8, 1);
        vecs[12] = mk(0, 0, 0, 32'h0,         0, 0, 3'b010, 12'h080, 4'h0, 4'h8, 1);
        vecs[13] = mk(0, 0, 0, 32'h0,         0, 0, 3'b100, 12'h800, 4'h0, 4'h8, 1);
        vecs[14] = mk(0, 0, 0, 32'h0,         0, 0, 3'b000, 12'h000, 4'h8, 4'h8, 0);
        // flush with write in the same cycle
        vecs[15] = mk(0, 0, 1, 32'h8000_0000, 1, 1, 3'b001, 12'h007, 4'h8, 4'h7, 1);
        vecs[16] = mk(0, 0, 1, 32'h5,         0, 1, 3'b011, 12'h071, 4'h8, 4'h1, 1);
        vecs[17] = mk(1, 0, 1, 32'h0,         0, 0, 3'b011, 12'h071, 4'h8, 4'h1, 1);
        vecs[18] = mk(0, 1, 1, 32'h0,         0, 0, 3'b000, 12'h071, 4'h8, 4'h8, 0);
        // flush with a valid oldest entry: no retire; stall also blocks retire
        vecs[19] = mk(0, 0, 1, 32'h1,         1, 1, 3'b001, 12'h713, 4'h8, 4'h3, 1);
        vecs[20] = mk(0, 0, 1, 32'hFFFF_FFFF, 1, 0, 3'b011, 12'h136, 4'h8, 4'h6, 1);
        vecs[21] = mk(0, 0, 0, 32'h0,         0, 0, 3'b110, 12'h360, 4'h8, 4'h6, 1);
        vecs[22] = mk(1, 0, 1, 32'h9,         0, 0, 3'b110, 12'h360, 4'h8, 4'h6, 1);
        vecs[23] = mk(0, 1, 0, 32'h0,         0, 0, 3'b000, 12'h360, 4'h8, 4'h8, 0);
        // refill; same-edge retire and write
        vecs[24] = mk(0, 0, 1, 32'h0,         0, 0, 3'b001, 12'h608, 4'h8, 4'h8, 1);
        vecs[25] = mk(0, 0, 1, 32'h8000_0000, 0, 0, 3'b011, 12'h084, 4'h8, 4'h4, 1);
        vecs[26] = mk(0, 0, 1, 32'h2,         1, 1, 3'b111, 12'h843, 4'h8, 4'h3, 1);
        vecs[27] = mk(0, 0, 0, 32'h0,         0, 0, 3'b110, 12'h430, 4'h8, 4'h3, 1);
        vecs[28] = mk(0, 0, 1, 32'h0,         0, 0, 3'b101, 12'h308, 4'h4, 4'h8, 1);
        vecs[29] = mk(0, 0, 1, 32'h0,         1, 0, 3'b011, 12'h08A, 4'h3, 4'hA, 1);
        vecs[30] = mk(0, 0, 1, 32'h0,         0, 1, 3'b111, 12'h8A9, 4'h3, 4'h9, 1);

        rst_n = 1'b1; write = 0; in_val = '0; carry = 0; ovf = 0; stall = 0; flush = 0;
        #1 rst_n = 1'b0;
        #1 check_all("in_reset", 3'b000, 12'h000, 4'h8, 4'h8, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_all("reset_release", 3'b000, 12'h000, 4'h8, 4'h8, 0);
        $display("[TB] reset release: valid=%b arch=%h fwd=%h hit=%b",
                 stage_valid, arch_flags, fwd_flags, fwd_hit);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            stall = vecs[i].stall; flush = vecs[i].flush; write = vecs[i].write;
            in_val = vecs[i].in; carry = vecs[i].c; ovf = vecs[i].v;
            @(posedge clk); #1;
            check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ef, vecs[i].ea,
                      vecs[i].efw, vecs[i].eh);
            $display("[TB] vec %0d: s=%b f=%b w=%b in=%h -> valid=%b flags=%h arch=%h fwd=%h hit=%b",
                     i, stall, flush, write, in_val, stage_valid, stage_flags,
                     arch_flags, fwd_flags, fwd_hit);
        end

        // Asynchronous reset between edges with all stages valid.
        @(negedge clk);
        write = 0; stall = 0; flush = 0; in_val = '0; carry = 0; ovf = 0;
        #2 rst_n = 1'b0;
        #1 check_all("async_reset", 3'b000, 12'h000, 4'h8, 4'h8, 0);
        $display("[TB] async reset: valid=%b arch=%h fwd=%h hit=%b",
                 stage_valid, arch_flags, fwd_flags, fwd_hit);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_all("post_reset_idle", 3'b000, 12'h000, 4'h8, 4'h8, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_flag_fwd_pipe
